// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory answering core load/store
// requests with a fixed response latency.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_we                 1 = store, 0 = load
//   req_addr               byte address
//   req_wdata              right-aligned store data
//   req_size               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned           loads: zero-extend when 1, sign-extend when 0
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              extended load data, 0 for stores and errors
//   rsp_err                misaligned, out of range or illegal size
//
// Memory storage is 32-bit words with byte lanes.
// The lane, extension and store-data logic assumes n >= 32.
module data_mem_responder #(
   parameter int unsigned n       = 32,
   parameter int unsigned depth   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [n-1:0] req_addr,
   input  logic [n-1:0] req_wdata,
   input  logic [1:0]   req_size,
   input  logic         req_unsigned,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [n-1:0] rsp_rdata,
   output logic         rsp_err
);

   localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;

   // Request fields captured at acceptance
   logic            we_q;
   logic [n-1:0]    addr_q;
   logic [n-1:0]    wdata_q;
   logic [1:0]      size_q;
   logic            unsigned_q;

   logic [31:0]     mem [depth];

   logic [AW-1:0]   idx_c;
   logic            misalign_c;
   logic            oor_c;
   logic            err_c;
   logic            commit_c;
   logic [3:0]      be_c;
   logic [31:0]     wbus_c;
   logic [31:0]     rd_word_c;
   logic [31:0]     shifted_c;
   logic [n-1:0]    load_c;

   // Error classification of the latched request
   always_comb begin
      idx_c      = addr_q[AW+1:2];
      oor_c      = ({2'b00, addr_q[n-1:2]} >= n'(depth));
      misalign_c = ((size_q == 2'b01) && addr_q[0]) ||
                   ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
      err_c      = misalign_c || oor_c || (size_q == 2'b11);
      commit_c   = (state == WAIT) && (cnt == '0);
   end

   // Store lane enables and replicated store data
   always_comb begin
      be_c   = 4'b0000;
      wbus_c = wdata_q[31:0];
      case (size_q)
         2'b00: begin
            be_c   = 4'b0001 << addr_q[1:0];
            wbus_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_c   = addr_q[1] ? 4'b1100 : 4'b0011;
            wbus_c = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            be_c   = 4'b1111;
            wbus_c = wdata_q[31:0];
         end
         default: begin
            be_c   = 4'b0000;
            wbus_c = wdata_q[31:0];
         end
      endcase
   end

   // Load lane selection and extension
   always_comb begin
      rd_word_c = mem[idx_c];
      shifted_c = rd_word_c >> {addr_q[1:0], 3'b000};
      load_c    = n'(rd_word_c);
      case (size_q)
         2'b00: load_c = unsigned_q ? n'(shifted_c[7:0])
                                    : {{(n-8){shifted_c[7]}}, shifted_c[7:0]};
         2'b01: load_c = unsigned_q ? n'(shifted_c[15:0])
                                    : {{(n-16){shifted_c[15]}}, shifted_c[15:0]};
         default: load_c = n'(rd_word_c);
      endcase
   end

   // Memory array: no reset; a reset on the commit edge suppresses the store
   always_ff @(posedge clk) begin
      if (!reset && commit_c && we_q && !err_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[idx_c][8*i +: 8] <= wbus_c[8*i +: 8];
         end
      end
   end

   // Control FSM with registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  we_q       <= req_we;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  cnt        <= CW'(LATENCY - 1);
                  req_ready  <= 1'b0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err_c;
                  rsp_rdata <= (err_c || we_q) ? '0 : load_c;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios followed by random
// load/store traffic, compared against a byte-addressed reference memory.
module tb_data_mem_responder;

   localparam int unsigned N     = 32;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [N-1:0]  req_addr;
   logic [N-1:0]  req_wdata;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [N-1:0]  rsp_rdata;
   logic          rsp_err;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int last_acc = -100;
   bit prev_fast = 1'b0;

   logic [7:0] mb [4*DEPTH];

   data_mem_responder #(.n(N), .depth(DEPTH), .LATENCY(LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference behaviour on a plain byte array
   task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rd, output logic er);
      int nb;
      logic [31:0] v;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      er = (size == 2'd3) || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
      rd = 32'd0;
      if (er) return;
      if (we) begin
         for (int i = 0; i < nb; i++) mb[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < nb; i++) v = v | (32'(mb[int'(addr) + i]) << (8*i));
         if (uns || nb == 4) rd = v;
         else if (nb == 1)   rd = 32'($signed(v[7:0]));
         else                rd = 32'($signed(v[15:0]));
      end
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge clk);
      prev_fast = 1'b0;
   endtask

   // One request/response; called and returning at a falling edge
   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input int hold,
                       input string tag);
      logic [31:0] exp_rd;
      logic        exp_er;
      int          k;
      int          acc;
      model(we, addr, wdata, size, uns, exp_rd, exp_er);
      check({tag, "/ready_idle"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      rsp_ready    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      acc = cycle;
      if (prev_fast) check({tag, "/throughput"}, 32'(acc - last_acc), 32'(LAT + 2));
      // Scramble inputs: the latched request must be unaffected
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      rsp_ready    = (hold == 0);
      check({tag, "/ready_busy"}, 32'(req_ready), 32'd0);
      k = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end while (!rsp_valid && k < 40);
      check({tag, "/latency"}, 32'(k), 32'(LAT));
      check({tag, "/rdata"}, rsp_rdata, exp_rd);
      check({tag, "/err"}, 32'(rsp_err), 32'(exp_er));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
         check({tag, "/hold_err"}, 32'(rsp_err), 32'(exp_er));
         check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "/done_ready"}, 32'(req_ready), 32'd1);
      last_acc  = acc;
      prev_fast = (hold == 0);
   endtask

   initial begin
      logic        r_we;
      logic [31:0] r_addr;
      logic [1:0]  r_size;
      logic [31:0] dummy_rd;
      logic        dummy_er;
      int          gap;

      reset        = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      rsp_ready    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset/req_ready", 32'(req_ready), 32'd1);
      check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset/rsp_rdata", rsp_rdata, 32'd0);
      check("reset/rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      idle(1);

      // Give words 0..15 known contents
      for (int w = 0; w < 16; w++)
         xact(1'b1, 32'(4*w), $urandom, 2'b10, 1'b0, 0, "init");

      // Word store then load
      xact(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, "sw10");
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "lw10");

      // Byte store and signed/unsigned byte loads
      xact(1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0, 0, "sw10b");
      xact(1'b1, 32'h13, 32'hFFFFFF80, 2'b00, 1'b0, 1, "sb13");
      xact(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, "lb13");
      xact(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, "lbu13");
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "lw10b");

      // Half store and signed/unsigned half loads
      xact(1'b1, 32'h16, 32'h1234BEEF, 2'b01, 1'b0, 0, "sh16");
      xact(1'b0, 32'h16, 32'h0, 2'b01, 1'b0, 0, "lh16");
      xact(1'b0, 32'h16, 32'h0, 2'b01, 1'b1, 0, "lhu16");
      xact(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 0, "lw14");

      // Error cases leave memory untouched
      xact(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 0, "lw11_err");
      xact(1'b1, 32'h15, 32'hAAAA5555, 2'b01, 1'b0, 0, "sh15_err");
      xact(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 0, "lw_oor");
      xact(1'b1, 32'h1000, 32'h55555555, 2'b10, 1'b0, 0, "sw_oor");
      xact(1'b1, 32'h10, 32'h99999999, 2'b11, 1'b0, 0, "size11_err");
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "lw10_after_err");
      xact(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 0, "lw14_after_err");

      // Response back-pressure
      xact(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, "hold5");

      // Reset while a store waits: store abandoned
      idle(1);
      check("rst_wait/req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'hCAFEF00D;
      req_size  = 2'b10;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_wait/req_ready_after", 32'(req_ready), 32'd1);
      check("rst_wait/rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_wait/rsp_rdata", rsp_rdata, 32'd0);
      check("rst_wait/rsp_err", 32'(rsp_err), 32'd0);
      repeat (3) @(negedge clk);
      check("rst_wait/no_rsp", 32'(rsp_valid), 32'd0);
      idle(0);
      xact(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, "lw20_old");

      // Random traffic
      for (int t = 0; t < 250; t++) begin
         r_we   = 1'($urandom);
         r_size = 2'($urandom);
         case ($urandom_range(0, 9))
            0:       r_addr = 32'h1000 + $urandom_range(0, 255);
            1:       r_addr = $urandom;
            default: r_addr = $urandom_range(0, 63);
         endcase
         gap = $urandom_range(0, 3);
         if (gap == 0) idle(1);
         xact(r_we, r_addr, $urandom, r_size, 1'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, "rand");
      end

      // Final sweep of the tracked region
      for (int w = 0; w < 16; w++)
         xact(1'b0, 32'(4*w), 32'h0, 2'b10, 1'b0, 0, "sweep");

      model(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, dummy_rd, dummy_er);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
